viterbi_ber_checker: RTL and testbench

//  Synthesizable multi-lane bit-error scoreboard for the conv-encoder / channel / Viterbi path.

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/ber_ref_fifo.sv | 65 ++++++
 rtl/viterbi_ber_checker.sv | 202 ++++++++++++++++++++
 tb/tb_viterbi_ber_checker.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi bit-error scoreboard.
package viterbi_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_DONE = 2'd2
  } chk_state_t;

  // Widest word the popcount helper handles; LANES must not exceed this.
  localparam int POP_W = 32;

  // Number of set bits in a (zero-extended) lane word.
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ber_ref_fifo.sv
// DEPTH x LANES synchronous FIFO holding reference words until the decoder
// output catches up. Read data is first-word fall-through (combinational).
module ber_ref_fifo #(
  parameter int LANES = 1,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [LANES-1:0] wdata_i,
  input  logic             pop_i,
  output logic [LANES-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [LANES-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when a pop frees the slot.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Next-pointer computation; clear wins over traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Multi-lane bit-error scoreboard: buffers reference words and compares them
// against decoder words that arrive a variable number of cycles later.
// Handshake: a word is transferred on any cycle its valid is high while the
// checker is in RUN (there is no ready; the checker never stalls a source).
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16,
  parameter int DROP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             ref_valid_i,
  input  logic [LANES-1:0] ref_i,
  input  logic             dut_valid_i,
  input  logic [LANES-1:0] dut_i,
  output logic [CNT_W-1:0] good_ct_o,
  output logic [CNT_W-1:0] bad_ct_o,
  output logic [CNT_W-1:0] bad_bit_ct_o,
  output logic [CNT_W-1:0] first_bad_o,
  output logic             err_seen_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      DROP_C  = 32'(DROP);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [31:0]      ref_drop_q, ref_drop_d;
  logic [31:0]      dut_drop_q, dut_drop_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             run;
  logic             ref_take, dut_take;
  logic             ref_keep, dut_keep;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [LANES-1:0] fifo_rdata;
  logic [LANES-1:0] xor_w;
  logic [31:0]      pc_w;
  logic [32:0]      bit_sum;
  logic             word_bad;
  logic             last_cmp;

  // start_i takes the cycle for clearing, so no traffic is accepted with it.
  assign run      = (state_q == CHK_RUN) && !start_i;
  assign ref_take = run && ref_valid_i;
  assign dut_take = run && dut_valid_i;
  assign ref_keep = ref_take && (ref_drop_q == DROP_C);
  assign dut_keep = dut_take && (dut_drop_q == DROP_C);

  assign fifo_pop  = dut_keep && !fifo_empty;
  assign fifo_push = ref_keep && (!fifo_full || fifo_pop);

  // An empty compare has nothing to match, so every lane counts as wrong.
  assign xor_w    = fifo_empty ? '1 : (fifo_rdata ^ dut_i);
  assign pc_w     = popcount(32'(xor_w));
  assign bit_sum  = 33'(bits_q) + 33'(pc_w);
  assign word_bad = (pc_w != 32'd0);
  assign last_cmp = dut_keep && (num_q != '0) && ((idx_q + CNT_W'(1)) == num_q);

  ber_ref_fifo #(
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_i),
    .push_i (fifo_push),
    .wdata_i(ref_i),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= CHK_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start restarts from anywhere, final compare finishes.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = CHK_RUN;
    end else begin
      case (state_q)
        CHK_RUN:  if (last_cmp) state_d = CHK_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy_o      = (state_q == CHK_RUN);
    done_o      = (state_q == CHK_DONE);
    dbg_state_o = state_q;
  end

  // Drop counters, stickies and saturating result counters.
  always_comb begin
    num_d      = num_q;
    good_d     = good_q;
    bad_d      = bad_q;
    bits_d     = bits_q;
    first_d    = first_q;
    idx_d      = idx_q;
    ref_drop_d = ref_drop_q;
    dut_drop_d = dut_drop_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (start_i) begin
      num_d      = num_words_i;
      good_d     = '0;
      bad_d      = '0;
      bits_d     = '0;
      first_d    = '0;
      idx_d      = '0;
      ref_drop_d = '0;
      dut_drop_d = '0;
      err_d      = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      if (ref_take && !ref_keep) ref_drop_d = ref_drop_q + 32'd1;
      if (dut_take && !dut_keep) dut_drop_d = dut_drop_q + 32'd1;
      if (ref_keep && fifo_full && !fifo_pop) ovf_d = 1'b1;
      if (dut_keep) begin
        idx_d = idx_q + CNT_W'(1);
        if (fifo_empty) unf_d = 1'b1;
        if (word_bad) begin
          if (bad_q != CNT_MAX) bad_d = bad_q + CNT_W'(1);
          bits_d = (bit_sum > 33'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
          if (!err_q) begin
            first_d = idx_q;
            err_d   = 1'b1;
          end
        end else begin
          if (good_q != CNT_MAX) good_d = good_q + CNT_W'(1);
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      bits_q     <= '0;
      first_q    <= '0;
      idx_q      <= '0;
      ref_drop_q <= '0;
      dut_drop_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      num_q      <= num_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      bits_q     <= bits_d;
      first_q    <= first_d;
      idx_q      <= idx_d;
      ref_drop_q <= ref_drop_d;
      dut_drop_q <= dut_drop_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign good_ct_o    = good_q;
  assign bad_ct_o     = bad_q;
  assign bad_bit_ct_o = bits_q;
  assign first_bad_o  = first_q;
  assign err_seen_o   = err_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: instance A (LANES=1, DEPTH=64, CNT_W=16,
// DROP=0) and instance B (LANES=4, DEPTH=8, CNT_W=4, DROP=2), checked against
// a queue-based reference model of the scoreboard rules.
module tb_viterbi_ber_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_start, a_rv, a_dv;
  logic [15:0] a_num;
  logic [0:0]  a_ref, a_dut;
  logic [15:0] a_good, a_bad, a_bits, a_first;
  logic        a_err, a_ovf, a_unf, a_busy, a_done;
  logic [1:0]  a_dbg;

  viterbi_ber_checker #(.LANES(1), .DEPTH(64), .CNT_W(16), .DROP(0)) u_a (
    .clk(clk), .rst(rst), .start_i(a_start), .num_words_i(a_num),
    .ref_valid_i(a_rv), .ref_i(a_ref), .dut_valid_i(a_dv), .dut_i(a_dut),
    .good_ct_o(a_good), .bad_ct_o(a_bad), .bad_bit_ct_o(a_bits),
    .first_bad_o(a_first), .err_seen_o(a_err), .overflow_o(a_ovf),
    .underflow_o(a_unf), .busy_o(a_busy), .done_o(a_done), .dbg_state_o(a_dbg)
  );

  // ---------------- instance B ----------------
  logic       b_start, b_rv, b_dv;
  logic [3:0] b_num, b_ref, b_dut;
  logic [3:0] b_good, b_bad, b_bits, b_first;
  logic       b_err, b_ovf, b_unf, b_busy, b_done;
  logic [1:0] b_dbg;

  viterbi_ber_checker #(.LANES(4), .DEPTH(8), .CNT_W(4), .DROP(2)) u_b (
    .clk(clk), .rst(rst), .start_i(b_start), .num_words_i(b_num),
    .ref_valid_i(b_rv), .ref_i(b_ref), .dut_valid_i(b_dv), .dut_i(b_dut),
    .good_ct_o(b_good), .bad_ct_o(b_bad), .bad_bit_ct_o(b_bits),
    .first_bad_o(b_first), .err_seen_o(b_err), .overflow_o(b_ovf),
    .underflow_o(b_unf), .busy_o(b_busy), .done_o(b_done), .dbg_state_o(b_dbg)
  );

  // ---------------- reference model ----------------
  int          p_lanes [2] = '{1, 4};
  int          p_depth [2] = '{64, 8};
  int unsigned p_max   [2] = '{65535, 15};
  int unsigned p_drop  [2] = '{0, 2};
  logic [3:0]  p_mask  [2] = '{4'h1, 4'hF};

  int          m_st [2];   // 0 idle, 1 run, 2 done
  int unsigned m_num[2], m_good[2], m_bad[2], m_bits[2], m_first[2], m_idx[2];
  int unsigned m_rdrop[2], m_ddrop[2];
  bit          m_err[2], m_ovf[2], m_unf[2];
  logic [3:0]  exp_q0[$];
  logic [3:0]  exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void m_reset(input int i);
    m_st[i] = 0; m_num[i] = 0; m_good[i] = 0; m_bad[i] = 0; m_bits[i] = 0;
    m_first[i] = 0; m_idx[i] = 0; m_rdrop[i] = 0; m_ddrop[i] = 0;
    m_err[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    if (i == 0) exp_q0.delete();
    else        exp_q1.delete();
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock of scoreboard behaviour: compare (pop) first, then store.
  function automatic void m_step(input int i, input bit st, input int unsigned num,
                                 input bit rv, input logic [3:0] r,
                                 input bit dv, input logic [3:0] d);
    int unsigned nb;
    int          qs;
    logic [3:0]  w;
    if (st) begin
      m_reset(i);
      m_st[i]  = 1;
      m_num[i] = num & p_max[i];
      return;
    end
    if (m_st[i] != 1) return;
    if (dv) begin
      if (m_ddrop[i] < p_drop[i]) m_ddrop[i]++;
      else begin
        qs = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (qs == 0) begin
          nb = p_lanes[i];
          m_unf[i] = 1;
        end else begin
          if (i == 0) w = exp_q0.pop_front();
          else        w = exp_q1.pop_front();
          nb = $countones((w ^ d) & p_mask[i]);
        end
        if (nb != 0) begin
          m_bad[i]  = sat(m_bad[i] + 1, p_max[i]);
          m_bits[i] = sat(m_bits[i] + nb, p_max[i]);
          if (!m_err[i]) m_first[i] = m_idx[i];
          m_err[i] = 1;
        end else begin
          m_good[i] = sat(m_good[i] + 1, p_max[i]);
        end
        m_idx[i] = (m_idx[i] + 1) % (p_max[i] + 1);
        if (m_num[i] != 0 && m_idx[i] == m_num[i]) m_st[i] = 2;
      end
    end
    if (rv) begin
      if (m_rdrop[i] < p_drop[i]) m_rdrop[i]++;
      else begin
        qs = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (qs < p_depth[i]) begin
          if (i == 0) exp_q0.push_back(r & p_mask[i]);
          else        exp_q1.push_back(r & p_mask[i]);
        end else begin
          m_ovf[i] = 1;
        end
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic check(input int i, input string tag);
    logic [15:0] g, b, bb, f;
    logic        e, o, u, bs, dn;
    logic [1:0]  sd;
    if (i == 0) begin
      g = a_good; b = a_bad; bb = a_bits; f = a_first;
      e = a_err; o = a_ovf; u = a_unf; bs = a_busy; dn = a_done; sd = a_dbg;
    end else begin
      g = {12'd0, b_good}; b = {12'd0, b_bad}; bb = {12'd0, b_bits}; f = {12'd0, b_first};
      e = b_err; o = b_ovf; u = b_unf; bs = b_busy; dn = b_done; sd = b_dbg;
    end
    chk(tag, "good",      32'(g),  m_good[i]);
    chk(tag, "bad",       32'(b),  m_bad[i]);
    chk(tag, "bad_bit",   32'(bb), m_bits[i]);
    chk(tag, "first_bad", 32'(f),  m_first[i]);
    chk(tag, "err_seen",  32'(e),  32'(m_err[i]));
    chk(tag, "overflow",  32'(o),  32'(m_ovf[i]));
    chk(tag, "underflow", 32'(u),  32'(m_unf[i]));
    chk(tag, "busy",      32'(bs), 32'(m_st[i] == 1));
    chk(tag, "done",      32'(dn), 32'(m_st[i] == 2));
    chk(tag, "state",     32'(sd), 32'(m_st[i]));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input int i, input bit st, input int unsigned num,
                       input bit rv, input logic [3:0] r, input bit dv, input logic [3:0] d);
    a_start = 0; a_num = '0; a_rv = 0; a_ref = '0; a_dv = 0; a_dut = '0;
    b_start = 0; b_num = '0; b_rv = 0; b_ref = '0; b_dv = 0; b_dut = '0;
    if (i == 0) begin
      a_start = st; a_num = 16'(num); a_rv = rv; a_ref = r[0]; a_dv = dv; a_dut = d[0];
    end else begin
      b_start = st; b_num = 4'(num); b_rv = rv; b_ref = r; b_dv = dv; b_dut = d;
    end
    @(posedge clk);
    if (rst) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(i, st, num, rv, r, dv, d);
    end
    @(negedge clk);
  endtask

  // Reference stream on A with the decoder copy trailing by 'delay' cycles;
  // decoder bits at compare indices f0/f1/f2 are flipped.
  task automatic stream_a(input string tag, input int nref, input int delay,
                          input int f0, input int f1, input int f2);
    logic [3:0] rbuf [512];
    logic [3:0] r, d;
    bit         rv, dv;
    int         k;
    for (int t = 0; t < nref + delay; t++) begin
      rv = (t < nref);
      r  = 4'($urandom_range(0, 1));
      if (rv) rbuf[t] = r;
      k  = t - delay;
      dv = (k >= 0) && (k < nref);
      d  = 4'h0;
      if (dv) begin
        d = rbuf[k];
        if (k == f0 || k == f1 || k == f2) d = d ^ 4'h1;
      end
      cycle(0, 0, 0, rv, r, dv, d);
      if (t % 37 == 0) check(0, tag);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0] w [16];
    logic [3:0] lst[$];
    logic [3:0] x, d;

    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check(0, "reset_a");
    check(1, "reset_b");
    rst = 1'b0;

    // Matched stream, 40-cycle decoder latency.
    cycle(0, 1, 256, 0, 0, 0, 0);
    stream_a("t1", 256, 40, -1, -1, -1);
    check(0, "t1_end");
    chk("t1", "good_256", 32'(a_good), 256);
    chk("t1", "done_set", 32'(a_done), 1);

    // Same with three flipped decoder bits.
    cycle(0, 1, 256, 0, 0, 0, 0);
    stream_a("t2", 256, 40, 10, 11, 200);
    check(0, "t2_end");
    chk("t2", "bad_3",    32'(a_bad),   3);
    chk("t2", "first_10", 32'(a_first), 10);
    chk("t2", "good_253", 32'(a_good),  253);

    // LANES=4, DROP=2: decoder word 5 (post-drop) fully inverted.
    for (int k = 0; k < 12; k++) w[k] = 4'($urandom_range(0, 15));
    cycle(1, 1, 10, 0, 0, 0, 0);
    for (int t = 0; t < 15; t++) begin
      d = 4'h0;
      if (t >= 3) d = w[t-3] ^ ((t - 3 == 7) ? 4'hF : 4'h0);
      cycle(1, 0, 0, t < 12, (t < 12) ? w[t] : 4'h0, t >= 3, d);
      check(1, "t3");
    end
    chk("t3", "bad_1",   32'(b_bad),   1);
    chk("t3", "bits_4",  32'(b_bits),  4);
    chk("t3", "first_5", 32'(b_first), 5);
    chk("t3", "done",    32'(b_done),  1);

    // DEPTH=8 overflow, ninth stored word lost, then underflow.
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      w[k] = 4'($urandom_range(0, 15));
      cycle(1, 0, 0, 1, w[k], 0, 0);
    end
    check(1, "t4_fill");
    chk("t4", "overflow", 32'(b_ovf), 1);
    for (int k = 0; k < 11; k++) begin
      cycle(1, 0, 0, 0, 0, 1, w[k]);
      check(1, "t4_drain");
    end
    chk("t4", "good_8", 32'(b_good), 8);
    chk("t4", "unf",    32'(b_unf),  1);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 1, 4'h5);
    check(1, "t4_unf");
    chk("t4", "bad_1_unf", 32'(b_bad), 1);

    // Push+pop while full, then bad-count saturation at 15.
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      w[k] = 4'($urandom_range(0, 15));
      cycle(1, 0, 0, 1, w[k], 0, 0);
    end
    cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    x = 4'($urandom_range(0, 15));
    cycle(1, 0, 0, 1, x, 1, w[2]);
    check(1, "t5_full");
    chk("t5", "no_ovf", 32'(b_ovf), 0);
    lst.delete();
    for (int k = 3; k < 10; k++) lst.push_back(w[k]);
    lst.push_back(x);
    for (int k = 0; k < 20; k++) begin
      d = (lst.size() != 0) ? ~lst.pop_front() : 4'($urandom_range(0, 15));
      cycle(1, 0, 0, 0, 0, 1, d);
      check(1, "t5_sat");
    end
    chk("t5", "bad_15",  32'(b_bad),  15);
    chk("t5", "bits_15", 32'(b_bits), 15);

    // Restart mid-run, then reset with words still buffered.
    cycle(0, 1, 0, 0, 0, 0, 0);
    stream_a("t6a", 30, 5, -1, -1, -1);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check(0, "t6_restart");
    chk("t6", "good_0", 32'(a_good), 0);
    stream_a("t6b", 20, 5, -1, -1, -1);
    chk("t6", "good_20", 32'(a_good), 20);
    cycle(0, 0, 0, 1, 4'h1, 0, 0);
    cycle(0, 0, 0, 1, 4'h1, 0, 0);
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    check(0, "t6_rst");
    chk("t6", "rst_good", 32'(a_good), 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 4'h1);
    check(0, "t6_lost");

    // Random traffic on both instances.
    cycle(0, 1, $urandom_range(50, 150), 0, 0, 0, 0);
    for (int t = 0; t < 400; t++) begin
      cycle(0, 0, 0, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6, 4'($urandom_range(0, 1)));
      check(0, "rand_a");
    end
    cycle(1, 1, $urandom_range(0, 15), 0, 0, 0, 0);
    for (int t = 0; t < 300; t++) begin
      if (t == 150) cycle(1, 1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)));
      check(1, "rand_b");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
